timebase_ctrl: RTL

Acquisition timebase sequencer for the scope sample clock. It converts a timebase selection code into a legal 24-bit divide ratio and drives the N / run_flag inputs of the 24-bit clock divider. It safely stops, reloads and restarts the divider, counts sample edges on the divider output, and ends the run after a programmed sample depth. It sits between the front-panel/host control registers and the sample-clock divider.

---
 rtl/timebase_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/timebase_ctrl.sv
// Scope acquisition timebase sequencer: drives the sample-clock divider's N/run and counts
// div_clk rising edges up to a programmed depth. Optional TB_AUTO_REARM_EN: continuous re-arm.
module timebase_ctrl #(
    parameter int MIN_N      = 2,
    parameter int MAX_SEL    = 22,
    parameter int SETTLE_CYC = 4
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [4:0]  tb_sel,
    input  logic [15:0] depth,
    input  logic        start,
    input  logic        stop,
    input  logic        div_clk,
    output logic [23:0] div_N,
    output logic        div_run,
    output logic        sample_stb,
    output logic [15:0] sample_cnt,
    output logic        busy,
    output logic        acq_done
);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

    localparam int SCW = $clog2(SETTLE_CYC);

    state_t          state;
    state_t          state_nxt;
    logic [SCW-1:0]  settle_cnt;
    logic [15:0]     depth_q;
    logic            div_clk_q;
    logic            rise;
    logic            load;
    logic            settle_last;
    logic [4:0]      sel_eff;
    logic [15:0]     cnt_inc;

    assign rise        = div_clk & ~div_clk_q;
    assign sel_eff     = (tb_sel > 5'(MAX_SEL)) ? 5'(MAX_SEL) : tb_sel;
    assign settle_last = (settle_cnt == SCW'(SETTLE_CYC - 1));
    assign cnt_inc     = sample_cnt + 16'd1;

    assign div_run  = (state == RUN);
    assign busy     = (state == SETTLE) || (state == RUN);
    assign acq_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // zero depth finishes without ever letting the divider run
                if (settle_last) begin
                    state_nxt = (depth_q == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rise && (cnt_inc == depth_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
`ifdef TB_AUTO_REARM_EN
                state_nxt = SETTLE;
                load      = start;
`else
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SETTLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = IDLE;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            depth_q    <= 16'd0;
            div_N      <= 24'(MIN_N);
            sample_stb <= 1'b0;
            sample_cnt <= 16'd0;
            div_clk_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_clk_q  <= div_clk;
            sample_stb <= 1'b0;

            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            // div_N only moves on an accepted start, i.e. while div_run is low
            if (load) begin
                depth_q    <= depth;
                div_N      <= 24'(MIN_N) << sel_eff;
                sample_cnt <= 16'd0;
            end else if ((state == DONE) && (state_nxt == SETTLE)) begin
                sample_cnt <= 16'd0;
            end else if ((state == RUN) && rise && !stop && (sample_cnt != depth_q)) begin
                sample_stb <= 1'b1;
                sample_cnt <= cnt_inc;
            end
        end
    end

endmodule
